// File: rtl/gf2m_mul_inv_seq.sv
// gf2m_mul_inv_seq: iterative GF(2^W) multiply / inverse engine (polynomial basis).
// One MSB-first shift-and-add step per clock. Multiply takes W steps; inverse
// is W-1 rounds of (square, multiply-accumulate), i.e. 2*(W-1)*W steps.
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while idle
//   mode   in   0 = y = a*b, 1 = y = a^(2^W-2) (inverse), sampled with start
//   a      in   operand A, latched on the accepted start
//   b      in   operand B, latched on the accepted start (unused for inverse)
//   busy   out  high from the accepting edge until the completion edge
//   done   out  one-cycle completion pulse
//   y      out  result register, holds until the next completion
module gf2m_mul_inv_seq #(
  parameter int unsigned  W    = 8,
  parameter logic [W:0]   POLY = 9'h1F5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] y
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
  localparam logic [CW-1:0] LAST_PASS = CW'(W - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_SQR  = 2'd2,
    S_PRD  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  mul_q, mul_d;   // multiplier bits, consumed from the MSB
  logic [W-1:0]  r_q, r_d;       // running inverse product
  logic [W-1:0]  s_q, s_d;       // a^(2^k)
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pass_q, pass_d;
  logic [W-1:0]  y_q, y_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W-1:0]  x_op;
  logic [W-1:0]  step;
  logic          last_step;

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      mul_q   <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      pass_q  <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      mul_q   <= mul_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, step datapath and outputs
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    acc_d   = acc_q;
    mul_d   = mul_q;
    r_d     = r_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Multiplicand for the current phase; the multiplier is always mul_q
    case (state_q)
      S_MUL:   x_op = a_q;
      S_SQR:   x_op = s_q;
      S_PRD:   x_op = r_q;
      default: x_op = '0;
    endcase

    // acc*x + bit*x with reduction of the bit shifted out of position W-1
    step = {acc_q[W-2:0], 1'b0}
         ^ (acc_q[W-1] ? POLY[W-1:0] : '0)
         ^ (mul_q[W-1] ? x_op : '0);
    last_step = (cnt_q == LAST_STEP);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          acc_d  = '0;
          cnt_d  = '0;
          pass_d = '0;
          busy_d = 1'b1;
          if (mode) begin
            r_d     = W'(1);
            s_d     = a;
            mul_d   = a;
            state_d = S_SQR;
          end else begin
            mul_d   = b;
            state_d = S_MUL;
          end
        end
      end

      S_MUL: begin
        acc_d = step;
        mul_d = mul_q << 1;
        cnt_d = last_step ? '0 : cnt_q + CW'(1);
        if (last_step) begin
          y_d     = step;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_SQR: begin
        acc_d = step;
        mul_d = mul_q << 1;
        cnt_d = last_step ? '0 : cnt_q + CW'(1);
        if (last_step) begin
          // New square becomes the multiplier of the following product pass
          s_d     = step;
          mul_d   = step;
          acc_d   = '0;
          state_d = S_PRD;
        end
      end

      S_PRD: begin
        acc_d = step;
        mul_d = mul_q << 1;
        cnt_d = last_step ? '0 : cnt_q + CW'(1);
        if (last_step) begin
          r_d   = step;
          acc_d = '0;
          if (pass_q == LAST_PASS) begin
            y_d     = step;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            pass_d  = pass_q + CW'(1);
            mul_d   = s_q;
            state_d = S_SQR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
